// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD command sequencer.
//   - Peripheral register map (word addresses on the 10-bit register port).
//   - STATUS register bit positions.
//   - CMD register field offsets.
//   - Sequencer state encoding.
//   - Helpers to build the CMD word and the response word count.
package sd_pkg;

  // Peripheral register map
  localparam logic [9:0] SD_SPEED   = 10'd0;
  localparam logic [9:0] SD_CONTROL = 10'd1;
  localparam logic [9:0] SD_STATUS  = 10'd2;
  localparam logic [9:0] SD_CMD     = 10'd3;
  localparam logic [9:0] SD_ARG     = 10'd4;
  localparam logic [9:0] SD_RESP    = 10'd8;
  localparam logic [9:0] SD_DATA    = 10'd128;

  // STATUS bit indices
  localparam int STAT_CMD_RX_BUSY  = 0;
  localparam int STAT_DATA_RX_BUSY = 1;
  localparam int STAT_CMD_TX_BUSY  = 2;
  localparam int STAT_CMD_ERR      = 3;
  localparam int STAT_DATA_ERR     = 4;

  // CMD register field offsets
  localparam int CMD_IDX_LSB  = 0;
  localparam int CMD_RLEN_LSB = 8;
  localparam int CMD_DATA_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ARG  = 3'd1,
    S_WR_CMD  = 3'd2,
    S_SETTLE  = 3'd3,
    S_POLL    = 3'd4,
    S_RD_RESP = 3'd5,
    S_DONE    = 3'd6
  } seq_state_e;

  // CMD word: index at [5:0], response length at [14:8], data flag at [16].
  function automatic logic [31:0] cmd_word(input logic [5:0] cmd,
                                           input logic [6:0] resp_len,
                                           input logic       data);
    logic [31:0] w;
    w = '0;
    w[CMD_IDX_LSB  +: 6] = cmd;
    w[CMD_RLEN_LSB +: 7] = resp_len;
    w[CMD_DATA_BIT]      = data;
    return w;
  endfunction

  // Number of 32-bit RESP words covering resp_len bits: ceil(len/32), 0..4.
  function automatic logic [2:0] resp_nwords(input logic [6:0] resp_len);
    logic [7:0] s;
    s = {1'b0, resp_len} + 8'd31;
    return s[7:5];
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: bundles the CPU-side request/response handshake and
// the peripheral register port of the SD command sequencer.
//   slave  modport: the sequencer's view (accepts requests, drives the register port).
//   master modport: the environment's view (issues requests, models the peripheral).
interface sd_cmd_sequencer_if;
  // request channel
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_cmd;
  logic [31:0]  req_arg;
  logic [6:0]   req_resp_len;
  logic         req_data;
  // response channel
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_err;
  logic         rsp_timeout;
  // peripheral register port
  logic [9:0]   sd_addr;
  logic         sd_write_en;
  logic [31:0]  sd_write_val;
  logic [31:0]  sd_read_val;

  modport slave (
    input  req_valid, req_cmd, req_arg, req_resp_len, req_data,
    input  rsp_ready, sd_read_val,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    output sd_addr, sd_write_en, sd_write_val
  );

  modport master (
    output req_valid, req_cmd, req_arg, req_resp_len, req_data,
    output rsp_ready, sd_read_val,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    input  sd_addr, sd_write_en, sd_write_val
  );
endinterface

// File: rtl/sd_seq_timeout.sv
// sd_seq_timeout: saturating poll counter with clear, load and enable.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear_i      synchronous clear to zero (highest priority)
//   load_i       synchronous load of load_val_i
//   load_val_i   value to load
//   en_i         count enable; the counter stops at all-ones
//   tc_o         high while the count equals TIMEOUT_CYCLES-1
module sd_seq_timeout #(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [TIMEOUT_W-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 tc_o
);

  localparam logic [TIMEOUT_W-1:0] TC_VAL = TIMEOUT_CYCLES - 1'b1;

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD command per request handshake on the SD
// host register port (ARG write, CMD write, STATUS polling, RESP readback)
// and returns the response with error/timeout flags.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         sd_cmd_sequencer_if.slave:
//               req_*  command request (valid/ready)
//               rsp_*  128-bit response, error and timeout flags (valid/ready)
//               sd_*   peripheral register port; sd_read_val is combinational
//                      from sd_addr in the same cycle
// All outputs are registered; each state's outputs are set on the edge that
// enters it.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input logic                 clk,
  input logic                 reset,
  sd_cmd_sequencer_if.slave   bus
);

  seq_state_e   state_q;
  logic [5:0]   cmd_q;
  logic [31:0]  arg_q;
  logic [6:0]   rlen_q;
  logic         data_q;
  logic [2:0]   nwords_q;
  logic [1:0]   idx_q;

  logic         req_ready_q;
  logic         rsp_valid_q;
  logic [127:0] rsp_data_q;
  logic [1:0]   rsp_err_q;
  logic         rsp_timeout_q;
  logic [9:0]   sd_addr_q;
  logic         sd_we_q;
  logic [31:0]  sd_wval_q;

  logic [2:0]   nwords_d;
  logic         poll_busy;
  logic         tmo_clear;
  logic         tmo_en;
  logic         tmo_tc;

  assign nwords_d  = resp_nwords(rlen_q);
  assign poll_busy = bus.sd_read_val[STAT_CMD_RX_BUSY]  |
                     bus.sd_read_val[STAT_DATA_RX_BUSY] |
                     bus.sd_read_val[STAT_CMD_TX_BUSY];

  // Counter is zeroed while the CMD write is on the bus, so the first POLL
  // cycle sees a count of 0 and the timeout fires on the TIMEOUT_CYCLES-th
  // busy POLL cycle.
  assign tmo_clear = (state_q == S_WR_CMD);
  assign tmo_en    = (state_q == S_POLL) && poll_busy;

  sd_seq_timeout #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tmo_clear),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmo_en),
    .tc_o       (tmo_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      arg_q         <= '0;
      rlen_q        <= '0;
      data_q        <= 1'b0;
      nwords_q      <= '0;
      idx_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= '0;
      rsp_timeout_q <= 1'b0;
      sd_addr_q     <= SD_STATUS;
      sd_we_q       <= 1'b0;
      sd_wval_q     <= '0;
    end else begin
      // Write strobe is a single-cycle pulse unless a write state re-arms it.
      sd_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            cmd_q       <= bus.req_cmd;
            arg_q       <= bus.req_arg;
            rlen_q      <= bus.req_resp_len;
            data_q      <= bus.req_data;
            req_ready_q <= 1'b0;
            sd_addr_q   <= SD_ARG;
            sd_we_q     <= 1'b1;
            sd_wval_q   <= bus.req_arg;
            state_q     <= S_WR_ARG;
          end
        end
        S_WR_ARG: begin
          sd_addr_q <= SD_CMD;
          sd_we_q   <= 1'b1;
          sd_wval_q <= cmd_word(cmd_q, rlen_q, data_q);
          state_q   <= S_WR_CMD;
        end
        S_WR_CMD: begin
          rsp_data_q <= '0;
          sd_addr_q  <= SD_STATUS;
          state_q    <= S_SETTLE;
        end
        S_SETTLE: begin
          state_q <= S_POLL;
        end
        S_POLL: begin
          if (!poll_busy) begin
            rsp_err_q <= {bus.sd_read_val[STAT_DATA_ERR], bus.sd_read_val[STAT_CMD_ERR]};
            nwords_q  <= nwords_d;
            if (nwords_d == 3'd0) begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idx_q     <= 2'd0;
              sd_addr_q <= SD_RESP;
              state_q   <= S_RD_RESP;
            end
          end else if (tmo_tc) begin
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_RD_RESP: begin
          // Word idx lands at bits [127-32*idx -: 32], i.e. base (3-idx)*32.
          rsp_data_q[{~idx_q, 5'b0} +: 32] <= bus.sd_read_val;
          if ({1'b0, idx_q} == nwords_q - 3'd1) begin
            sd_addr_q   <= SD_STATUS;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q     <= idx_q + 2'd1;
            sd_addr_q <= SD_RESP + {8'b0, idx_q + 2'd1};
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= '0;
            rsp_timeout_q <= 1'b0;
            req_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          sd_addr_q   <= SD_STATUS;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.sd_addr      = sd_addr_q;
  assign bus.sd_write_en  = sd_we_q;
  assign bus.sd_write_val = sd_wval_q;

endmodule
